// File: rtl/mem_pkg.sv
// Shared defaults, FSM encoding and error-bit indices for the memInt memory responder.
package mem_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {IDLE, CLEAR} mem_state_e;

  localparam int ERR_RW   = 0;
  localparam int ERR_BUSY = 1;
endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage: one write port, one registered read port with enable.
module mem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Contents are deliberately not reset; only the read register is.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_comb rdata_d = re ? mem[raddr] : rdata_q;

  always_ff @(posedge clk)
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;

  assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// memInt memory-side responder: arbitrated RAM access, clear sweep, sticky errors, counters.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 2 ** ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              clear_req,
  output logic              busy,
  output logic [1:0]        err,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);
  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              last_ptr;

  assign last_ptr = (ptr_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      err_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
      CLEAR:   if (last_ptr)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    err_d     = err_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data_in;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          // Clear start wipes history, but an access on this same edge is still a busy violation.
          ptr_d           = '0;
          err_d           = '0;
          err_d[ERR_BUSY] = read | write;
          wr_d            = '0;
          rd_d            = '0;
        end else if (read && write) begin
          err_d[ERR_RW] = 1'b1;
        end else if (write) begin
          mem_we = 1'b1;
          if (wr_q != '1) wr_d = wr_q + CNT_W'(1);
        end else if (read) begin
          mem_re = 1'b1;
          if (rd_q != '1) rd_d = rd_q + CNT_W'(1);
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + ADDR_W'(1);
        if (read || write) err_d[ERR_BUSY] = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy     = (state_q == CLEAR);
    err      = err_q;
    wr_count = wr_q;
    rd_count = rd_q;
  end

  // Gating with rst_n makes a reset edge abort the sweep without zeroing one more word.
  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we & rst_n),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re & rst_n),
    .raddr (addr),
    .rdata (data_out)
  );
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder; a second instance with CNT_W=4 exercises counter saturation.
module tb_mem_responder;
  logic       clk = 1'b0;
  logic       rst_n, read, write, clear_req;
  logic [4:0] addr;
  logic [7:0] data_in, data_out, s_data_out;
  logic       busy, s_busy;
  logic [1:0] err, s_err;
  logic [15:0] wr_count, rd_count;
  logic [3:0]  s_wr_count, s_rd_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .data_in(data_in),
    .data_out(data_out), .clear_req(clear_req), .busy(busy), .err(err),
    .wr_count(wr_count), .rd_count(rd_count));

  mem_responder #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr), .data_in(data_in),
    .data_out(s_data_out), .clear_req(clear_req), .busy(s_busy), .err(s_err),
    .wr_count(s_wr_count), .rd_count(s_rd_count));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 50) begin step(); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s timeout busy=%b want 0", name, busy); end
  endtask

  task automatic do_clear();
    clear_req = 1'b1; step(); clear_req = 1'b0;
    wait_idle("clear_wait");
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(); step();
    checks++;
    if ({data_out, busy, err, wr_count, rd_count} !== 43'd0) begin
      errors++; $display("FAIL reset got d=%h b=%b e=%b w=%0d r=%0d want 0", data_out, busy, err, wr_count, rd_count);
    end
    checks++;
    if ({s_wr_count, s_rd_count, s_busy} !== 9'd0) begin
      errors++; $display("FAIL reset_sat got w=%0d r=%0d b=%b want 0", s_wr_count, s_rd_count, s_busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_clear_sweep();
    int n = 0;
    clear_req = 1'b1; step(); clear_req = 1'b0;
    while (busy && n < 50) begin n++; step(); end
    checks++;
    if (n != 32) begin errors++; $display("FAIL busy_len got %0d want 32", n); end
    for (int i = 0; i < 32; i++) begin
      read = 1'b1; addr = 5'(i); step();
      checks++;
      if (data_out !== 8'h00) begin errors++; $display("FAIL clear_rd[%0d] got %h want 00", i, data_out); end
    end
    read = 1'b0;
    checks++;
    if (rd_count !== 16'd32) begin errors++; $display("FAIL clear_rdcnt got %0d want 32", rd_count); end
  endtask

  task automatic test_data_addr();
    do_clear();
    for (int i = 0; i < 32; i++) begin
      write = 1'b1; addr = 5'(i); data_in = 8'(i); step();
    end
    write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read = 1'b1; addr = 5'(i); step();
      checks++;
      if (data_out !== 8'(i)) begin errors++; $display("FAIL da_rd[%0d] got %h want %h", i, data_out, 8'(i)); end
    end
    read = 1'b0;
    checks++;
    if (wr_count !== 16'd32 || rd_count !== 16'd32 || err !== 2'b00) begin
      errors++; $display("FAIL da_stat got w=%0d r=%0d e=%b want 32 32 00", wr_count, rd_count, err);
    end
  endtask

  task automatic test_conflict();
    write = 1'b1; addr = 5'd5; data_in = 8'h11; step(); write = 1'b0;
    read = 1'b1; write = 1'b1; addr = 5'd5; data_in = 8'hAA; step();
    read = 1'b0; write = 1'b0;
    checks++;
    if (err !== 2'b01 || wr_count !== 16'd33 || rd_count !== 16'd32 || data_out !== 8'h1F) begin
      errors++; $display("FAIL conflict got e=%b w=%0d r=%0d d=%h want 01 33 32 1f", err, wr_count, rd_count, data_out);
    end
    read = 1'b1; addr = 5'd5; step(); read = 1'b0;
    checks++;
    if (data_out !== 8'h11) begin errors++; $display("FAIL conflict_rd got %h want 11", data_out); end
  endtask

  task automatic test_busy_access();
    clear_req = 1'b1; step(); clear_req = 1'b0;
    step(); step(); step();
    write = 1'b1; addr = 5'd3; data_in = 8'h55; step(); write = 1'b0;
    checks++;
    if (err !== 2'b10 || wr_count !== 16'd0) begin
      errors++; $display("FAIL busy_acc got e=%b w=%0d want 10 0", err, wr_count);
    end
    wait_idle("busy_wait");
    read = 1'b1; addr = 5'd3; step(); read = 1'b0;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL busy_rd got %h want 00", data_out); end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < 32; i++) begin
      write = 1'b1; addr = 5'(i); data_in = 8'hFF; step();
    end
    write = 1'b0;
    read = 1'b1; addr = 5'd7; step(); read = 1'b0;
    clear_req = 1'b1; step(); clear_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    checks++;
    if ({busy, err, wr_count, rd_count, data_out} !== 43'd0) begin
      errors++; $display("FAIL rst_mid got b=%b e=%b w=%0d r=%0d d=%h want 0", busy, err, wr_count, rd_count, data_out);
    end
    for (int i = 0; i < 32; i++) begin
      if (i == 10 || i == 11) continue;
      read = 1'b1; addr = 5'(i); step();
      checks++;
      if (data_out !== ((i < 10) ? 8'h00 : 8'hFF)) begin
        errors++; $display("FAIL rst_mid_rd[%0d] got %h want %h", i, data_out, (i < 10) ? 8'h00 : 8'hFF);
      end
    end
    read = 1'b0;
  endtask

  task automatic test_saturation();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      write = 1'b1; addr = 5'(i); data_in = 8'(i); step();
    end
    write = 1'b0;
    checks++;
    if (s_wr_count !== 4'd15 || wr_count !== 16'd20) begin
      errors++; $display("FAIL sat got s=%0d w=%0d want 15 20", s_wr_count, wr_count);
    end
    clear_req = 1'b1; step(); clear_req = 1'b0;
    checks++;
    if (s_wr_count !== 4'd0 || s_busy !== 1'b1) begin
      errors++; $display("FAIL sat_clr got s=%0d b=%b want 0 1", s_wr_count, s_busy);
    end
    wait_idle("sat_wait");
  endtask

  initial begin
    rst_n = 1'b0; read = 1'b0; write = 1'b0; clear_req = 1'b0; addr = '0; data_in = '0;
    test_reset();
    test_clear_sweep();
    test_data_addr();
    test_conflict();
    test_busy_access();
    test_reset_mid_sweep();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the memInt read/write protocol: the end that mem_test drives. A 32x8 synchronous RAM with a registered read port.
- Adds a self-clearing sweep engine, sticky protocol-error flags and saturating access counters for bench observability.
- Sits behind the memInt interface's memory modport, opposite the test initiator.

Parameters:
- ADDR_W, 5, address width.
- DATA_W, 8, data width.
- DEPTH, 2**ADDR_W, number of words; always a power of two.
- CNT_W, 16, width of each access counter.

Ports:
- clk  in  1  sole clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- read  in  1  read strobe, sampled at posedge.
- write  in  1  write strobe, sampled at posedge.
- addr  in  ADDR_W  access address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered read data.
- clear_req  in  1  request to zero the whole array.
- busy  out  1  high while the clear sweep runs.
- err  out  2  sticky flags. [0] = read and write asserted in the same cycle. [1] = access attempted while busy.
- wr_count  out  CNT_W  accepted writes, saturating.
- rd_count  out  CNT_W  accepted reads, saturating.

Behaviour:
- Reset, when rst_n is low at posedge:
  - data_out=0, busy=0, err=0, wr_count=0, rd_count=0.
  - FSM goes to IDLE, sweep pointer goes to 0.
  - Array contents are not reset and stay undefined until a clear sweep runs.
- FSM states:
  - IDLE. clear_req=1 at a posedge moves to CLEAR. That same edge sets ptr=0 and zeroes err, wr_count and rd_count.
  - CLEAR. Each posedge writes mem[ptr]=0 and increments ptr. The edge that writes ptr==DEPTH-1 returns the FSM to IDLE.
  - busy equals (state==CLEAR), so busy is high for exactly DEPTH cycles.
  - clear_req is ignored while in CLEAR; no re-arm and no queuing.
- Accepted write: state IDLE, write=1, read=0, clear_req=0.
  - mem[addr] <= data_in at that edge.
  - wr_count increments, saturating at all-ones.
- Accepted read: state IDLE, read=1, write=0, clear_req=0.
  - data_out <= mem[addr] at that edge, so data is valid one cycle after the strobe is sampled.
  - rd_count increments, saturating.
- data_out holds its last value in every cycle without an accepted read, including the whole of CLEAR.
- read=1 and write=1 together in IDLE: no array or counter change, data_out holds, err[0] set.
- read or write high while in CLEAR, or on the IDLE edge where clear_req=1:
  - the access is dropped and err[1] is set;
  - clear_req takes priority.
- Write to A at edge n, then read of A at edge n+1: data_out at n+1 shows the newly written data.
- Error flags clear only on reset or at clear start.
- Address wrap: not applicable. addr is exactly ADDR_W bits and every value is valid.
- Reset during CLEAR:
  - the sweep is aborted at once and busy=0 after that edge;
  - words already zeroed stay zero, and words not yet reached keep their prior contents.
- No combinational path from any input to any output.

Decomposition:
- Package mem_pkg holds:
  - ADDR_W/DATA_W/DEPTH/CNT_W defaults;
  - state enum mem_state_e {IDLE, CLEAR};
  - error bit index constants ERR_RW=0 and ERR_BUSY=1.
- One sub-module, mem_array: DEPTH x DATA_W storage with one write port, one registered read port and a read enable.
- mem_responder keeps the FSM, arbitration, counters and flags.

Test Plan:
- Clear sweep: reset, then clear_req pulsed for 1 cycle.
  - busy is high for exactly 32 cycles, then drops.
  - Reading addr 0..31 returns data_out=0x00 one cycle after each read strobe.
  - rd_count=32.
- Data = address: write addr i with data i for i=0..31, then read back.
  - data_out==i each time; wr_count=32, rd_count=32, err=0.
- Read/write conflict: mem[5]=0x11, then read=1, write=1, addr=5, data_in=0xAA for one cycle.
  - err[0]=1, counts unchanged.
  - A following read of addr 5 returns 0x11.
- Access while busy: write addr 3 with 0x55 during cycle 4 of the sweep.
  - err[1]=1 and wr_count=0.
  - After the sweep, a read of addr 3 returns 0x00.
- Reset mid-sweep: fill 0xFF, clear_req, rst_n low at sweep cycle 10.
  - busy=0, counters 0, data_out=0 after that edge.
  - addr 0..9 read 0x00; addr 12..31 read 0xFF.
- Saturation (CNT_W=4): 20 accepted writes leave wr_count=15; a later clear_req resets it to 0.
